lc3_regfile_sb: RTL and testbench

- Parametrised register file for the LC-3 datapath, generalising the 8x16 source-register select.
- Holds NUM_REGS registers of DATA_W bits, with two read ports (SR1, SR2) and one write port (DR).
- Adds a per-register busy scoreboard so the control FSM can detect read-after-write and write-after-write hazards against issued, not-yet-written destinations.
- Sits between the control unit, the bus/ALU writeback and the ALU operand inputs.

---
 rtl/lc3_regfile_pkg.sv | 21 ++
 rtl/lc3_regfile_rdport.sv | 59 +++++
 rtl/lc3_regfile_sb.sv | 92 +++++++++
 tb/tb_lc3_regfile_sb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_regfile_pkg.sv
// lc3_regfile_pkg: shared constants and helpers for the LC-3 register file
// with busy scoreboard.
//   REGFILE_NUM_REGS / REGFILE_DATA_W : default geometry (8 x 16)
//   regfile_addr_w()                  : index width for a given register count
//   reg_idx_t                         : register index type for the default geometry
package lc3_regfile_pkg;

    localparam int REGFILE_NUM_REGS = 8;
    localparam int REGFILE_DATA_W   = 16;

    // Never narrower than one bit, so a degenerate count still elaborates far
    // enough for the top-level range check to report it.
    function automatic int regfile_addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int REGFILE_ADDR_W = regfile_addr_w(REGFILE_NUM_REGS);

    typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/lc3_regfile_rdport.sv
// lc3_regfile_rdport: one combinational read port of the register file.
// Configuration macro: REGFILE_BYPASS_EN (write-through forwarding).
// Ports:
//   regs     in  all register contents, packed
//   busy     in  scoreboard bit per register
//   sel      in  register index to read
//   wr_en    in  write port enable (used only for forwarding)
//   wr_idx   in  write port index (used only for forwarding)
//   wr_data  in  write port data (used only for forwarding)
//   data     out selected register value, 0 when sel is out of range
//   busy_out out scoreboard bit of the selected register, 0 when out of range
module lc3_regfile_rdport
    import lc3_regfile_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = regfile_addr_w(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             busy,
    input  logic [ADDR_W-1:0]               sel,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_idx,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               data,
    output logic                            busy_out
);

    logic hit;

    // Compare against every legal index instead of indexing directly, so an
    // out-of-range sel (non power-of-two NUM_REGS) simply matches nothing.
    always_comb begin
        data     = '0;
        busy_out = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == ADDR_W'(i)) begin
                data     = regs[i];
                busy_out = busy[i];
                hit      = 1'b1;
            end
        end
`ifdef REGFILE_BYPASS_EN
        // A register being written this cycle is already resolved: forward the
        // new value and drop its busy so the consumer does not stall.
        if (hit && wr_en && (wr_idx == sel)) begin
            data     = wr_data;
            busy_out = 1'b0;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^{wr_en, wr_idx, wr_data, hit};
`endif

endmodule

// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb: LC-3 register file (NUM_REGS x DATA_W, 2R/1W) with a
// per-register busy scoreboard for RAW/WAW hazard detection.
// Configuration macro: REGFILE_BYPASS_EN (write-through forwarding on reads).
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   LD_REG/DR/DR_DATA write port; also clears DR's busy bit
//   SR1/SR2           read indices; SR1_OUT/SR2_OUT combinational data
//   ISSUE_VALID/ISSUE_DR  marks a destination as pending (sets busy)
//   SR1_BUSY/SR2_BUSY source has a pending write; STALL = either
//   ISSUE_CONFLICT    WAW: issuing to a destination that stays busy
//   BUSY_VEC          scoreboard bit per register
module lc3_regfile_sb
    import lc3_regfile_pkg::*;
#(
    parameter int  NUM_REGS = REGFILE_NUM_REGS,
    parameter int  DATA_W   = REGFILE_DATA_W,
    localparam int ADDR_W   = regfile_addr_w(NUM_REGS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                LD_REG,
    input  logic [ADDR_W-1:0]   DR,
    input  logic [DATA_W-1:0]   DR_DATA,
    input  logic [ADDR_W-1:0]   SR1,
    input  logic [ADDR_W-1:0]   SR2,
    output logic [DATA_W-1:0]   SR1_OUT,
    output logic [DATA_W-1:0]   SR2_OUT,
    input  logic                ISSUE_VALID,
    input  logic [ADDR_W-1:0]   ISSUE_DR,
    output logic                SR1_BUSY,
    output logic                SR2_BUSY,
    output logic                STALL,
    output logic                ISSUE_CONFLICT,
    output logic [NUM_REGS-1:0] BUSY_VEC
);

    if (NUM_REGS < 2) begin : g_bad_num_regs
        $error("lc3_regfile_sb: NUM_REGS must be >= 2");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             set_vec;
    logic [NUM_REGS-1:0]             clr_vec;

    // One-hot decodes; out-of-range indices decode to nothing, which is what
    // makes out-of-range writes and issues no-ops.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_vec[i] = ISSUE_VALID & (ISSUE_DR == ADDR_W'(i));
            clr_vec[i] = LD_REG & (DR == ADDR_W'(i));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_vec[i])
                    regs[i] <= DR_DATA;
                // Set wins: a new issue to a register retiring this cycle
                // leaves it busy for the new owner.
                if (set_vec[i])
                    busy[i] <= 1'b1;
                else if (clr_vec[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    lc3_regfile_rdport #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .regs(regs), .busy(busy), .sel(SR1),
        .wr_en(LD_REG), .wr_idx(DR), .wr_data(DR_DATA),
        .data(SR1_OUT), .busy_out(SR1_BUSY)
    );

    lc3_regfile_rdport #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .regs(regs), .busy(busy), .sel(SR2),
        .wr_en(LD_REG), .wr_idx(DR), .wr_data(DR_DATA),
        .data(SR2_OUT), .busy_out(SR2_BUSY)
    );

    assign STALL          = SR1_BUSY | SR2_BUSY;
    // Advisory only; the issue is recorded regardless.
    assign ISSUE_CONFLICT = |(set_vec & busy & ~clr_vec);
    assign BUSY_VEC       = busy;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb_lc3_regfile_sb: directed vectors for lc3_regfile_sb in two geometries
// (8x16 default, 6x32). Stimulus pushes hand-computed expectations into a
// queue; a monitor on the falling edge pops and compares them.
module tb_lc3_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // DUT A: 8 x 16
    logic        a_rst, a_ld, a_iv;
    logic [2:0]  a_dr, a_s1, a_s2, a_idr;
    logic [15:0] a_d, a_o1, a_o2;
    logic        a_b1, a_b2, a_st, a_cf;
    logic [7:0]  a_bv;

    // DUT B: 6 x 32
    logic        b_rst, b_ld, b_iv;
    logic [2:0]  b_dr, b_s1, b_s2, b_idr;
    logic [31:0] b_d, b_o1, b_o2;
    logic        b_b1, b_b2, b_st, b_cf;
    logic [5:0]  b_bv;

    lc3_regfile_sb u_dut_a (
        .Clk(Clk), .Reset(a_rst), .LD_REG(a_ld), .DR(a_dr), .DR_DATA(a_d),
        .SR1(a_s1), .SR2(a_s2), .SR1_OUT(a_o1), .SR2_OUT(a_o2),
        .ISSUE_VALID(a_iv), .ISSUE_DR(a_idr), .SR1_BUSY(a_b1), .SR2_BUSY(a_b2),
        .STALL(a_st), .ISSUE_CONFLICT(a_cf), .BUSY_VEC(a_bv)
    );

    lc3_regfile_sb #(.NUM_REGS(6), .DATA_W(32)) u_dut_b (
        .Clk(Clk), .Reset(b_rst), .LD_REG(b_ld), .DR(b_dr), .DR_DATA(b_d),
        .SR1(b_s1), .SR2(b_s2), .SR1_OUT(b_o1), .SR2_OUT(b_o2),
        .ISSUE_VALID(b_iv), .ISSUE_DR(b_idr), .SR1_BUSY(b_b1), .SR2_BUSY(b_b2),
        .STALL(b_st), .ISSUE_CONFLICT(b_cf), .BUSY_VEC(b_bv)
    );

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] s1, s2;
        logic        b1, b2, cf;
        logic [7:0]  bv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void push(string name, int dut, logic [31:0] s1, logic [31:0] s2,
                                 logic b1, logic b2, logic cf, logic [7:0] bv);
        exp_t e;
        e.name = name; e.dut = dut; e.s1 = s1; e.s2 = s2;
        e.b1 = b1; e.b2 = b2; e.cf = cf; e.bv = bv;
        q.push_back(e);
    endfunction

    // Monitor: the combinational outputs are settled by the falling edge.
    always @(negedge Clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] g1, g2;
            logic        gb1, gb2, gst, gcf;
            logic [7:0]  gbv;
            e = q.pop_front();
            if (e.dut == 0) begin
                g1 = {16'h0, a_o1}; g2 = {16'h0, a_o2};
                gb1 = a_b1; gb2 = a_b2; gst = a_st; gcf = a_cf; gbv = a_bv;
            end else begin
                g1 = b_o1; g2 = b_o2;
                gb1 = b_b1; gb2 = b_b2; gst = b_st; gcf = b_cf; gbv = {2'b00, b_bv};
            end
            total++;
            if (g1 !== e.s1 || g2 !== e.s2 || gb1 !== e.b1 || gb2 !== e.b2 ||
                gst !== (e.b1 | e.b2) || gcf !== e.cf || gbv !== e.bv) begin
                bad++;
                $display("FAIL %s: got s1=%h s2=%h b1=%b b2=%b st=%b cf=%b bv=%h want s1=%h s2=%h b1=%b b2=%b st=%b cf=%b bv=%h",
                         e.name, g1, g2, gb1, gb2, gst, gcf, gbv,
                         e.s1, e.s2, e.b1, e.b2, e.b1 | e.b2, e.cf, e.bv);
            end
        end
    end

    task automatic drv_a(logic rst, logic ld, logic [2:0] dr, logic [15:0] d,
                         logic [2:0] s1, logic [2:0] s2, logic iv, logic [2:0] idr);
        @(posedge Clk); #1;
        a_rst = rst; a_ld = ld; a_dr = dr; a_d = d;
        a_s1 = s1; a_s2 = s2; a_iv = iv; a_idr = idr;
    endtask

    task automatic drv_b(logic rst, logic ld, logic [2:0] dr, logic [31:0] d,
                         logic [2:0] s1, logic [2:0] s2, logic iv, logic [2:0] idr);
        @(posedge Clk); #1;
        b_rst = rst; b_ld = ld; b_dr = dr; b_d = d;
        b_s1 = s1; b_s2 = s2; b_iv = iv; b_idr = idr;
    endtask

    initial begin
        a_rst = 1; a_ld = 0; a_dr = 0; a_d = 0; a_s1 = 0; a_s2 = 0; a_iv = 0; a_idr = 0;
        b_rst = 1; b_ld = 0; b_dr = 0; b_d = 0; b_s1 = 0; b_s2 = 0; b_iv = 0; b_idr = 0;

        // ---------------- DUT A: 8 x 16 ----------------
        drv_a(1, 0, 0, 16'h0, 3, 7, 0, 0);
        drv_a(0, 0, 0, 16'h0, 3, 7, 0, 0);
        push("reset_read", 0, 0, 0, 0, 0, 0, 8'h00);

        drv_a(0, 1, 5, 16'hBEEF, 5, 5, 0, 0);
        push("wr_same_cycle", 0, BYP ? 32'hBEEF : 32'h0, BYP ? 32'hBEEF : 32'h0, 0, 0, 0, 8'h00);

        drv_a(0, 0, 0, 16'h0, 5, 0, 0, 0);
        push("wr_read", 0, 32'hBEEF, 0, 0, 0, 0, 8'h00);

        drv_a(0, 0, 0, 16'h0, 2, 5, 1, 2);
        push("issue2", 0, 0, 32'hBEEF, 0, 0, 0, 8'h00);

        drv_a(0, 0, 0, 16'h0, 2, 5, 0, 0);
        push("raw_stall", 0, 0, 32'hBEEF, 1, 0, 0, 8'h04);

        drv_a(0, 1, 2, 16'h1234, 2, 5, 0, 0);
        push("raw_write", 0, BYP ? 32'h1234 : 32'h0, 32'hBEEF, !BYP, 0, 0, 8'h04);

        drv_a(0, 0, 0, 16'h0, 2, 5, 0, 0);
        push("raw_done", 0, 32'h1234, 32'hBEEF, 0, 0, 0, 8'h00);

        drv_a(0, 0, 0, 16'h0, 4, 4, 1, 4);
        push("issue4", 0, 0, 0, 0, 0, 0, 8'h00);

        drv_a(0, 1, 4, 16'hCAFE, 4, 0, 1, 4);
        push("set_clr", 0, BYP ? 32'hCAFE : 32'h0, 0, !BYP, 0, 0, 8'h10);

        drv_a(0, 0, 0, 16'h0, 4, 0, 0, 0);
        push("set_clr_after", 0, 32'hCAFE, 0, 1, 0, 0, 8'h10);

        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 6);
        push("issue6", 0, 0, 0, 0, 0, 0, 8'h10);

        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 6);
        push("waw", 0, 0, 0, 0, 0, 1, 8'h50);

        drv_a(0, 0, 0, 16'h0, 6, 4, 0, 0);
        push("waw_after", 0, 0, 32'hCAFE, 1, 1, 0, 8'h50);

        // Fill the scoreboard and leave reg[1]=AAAA.
        drv_a(0, 1, 1, 16'hAAAA, 0, 0, 1, 0);
        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 1);
        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 2);
        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 3);
        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 5);
        drv_a(0, 0, 0, 16'h0, 0, 0, 1, 7);
        drv_a(0, 0, 0, 16'h0, 1, 7, 0, 0);
        push("full", 0, 32'hAAAA, 0, 1, 1, 0, 8'hFF);

        drv_a(1, 1, 1, 16'h5555, 1, 3, 1, 3);
        drv_a(0, 0, 0, 16'h0, 1, 3, 0, 0);
        push("reset_mid", 0, 0, 0, 0, 0, 0, 8'h00);

        // ---------------- DUT B: 6 x 32 ----------------
        drv_b(1, 0, 0, 32'h0, 0, 0, 0, 0);
        drv_b(0, 1, 5, 32'hDEADBEEF, 5, 7, 0, 0);
        push("b_wr_same_cycle", 1, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0, 8'h00);

        drv_b(0, 1, 7, 32'h12345678, 5, 7, 0, 0);
        push("b_wr_oor", 1, 32'hDEADBEEF, 0, 0, 0, 0, 8'h00);

        drv_b(0, 0, 0, 32'h0, 7, 5, 1, 7);
        push("b_read_oor", 1, 0, 32'hDEADBEEF, 0, 0, 0, 8'h00);

        drv_b(0, 0, 0, 32'h0, 7, 5, 1, 5);
        push("b_issue_oor", 1, 0, 32'hDEADBEEF, 0, 0, 0, 8'h00);

        drv_b(0, 0, 0, 32'h0, 7, 5, 0, 0);
        push("b_busy", 1, 0, 32'hDEADBEEF, 0, 1, 0, 8'h20);

        @(posedge Clk);
        @(negedge Clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
